// File: rtl/hatch_ctrl.sv
// hatch_ctrl: incubation timer that advances the egg growth stage while warm and kills it after a long cold spell.
module hatch_ctrl #(
  parameter int TICKS_PER_SEC  = 1000,
  parameter int STAGE_SEC      = 5,
  parameter int COLD_LIMIT_SEC = 10,
  parameter int LAST_STAGE     = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       temp,
  output logic [3:0] num,
  output logic       running,
  output logic       hatched,
  output logic       dead
);
  localparam int TW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SW = STAGE_SEC > 1 ? $clog2(STAGE_SEC) : 1;
  localparam int CW = COLD_LIMIT_SEC > 1 ? $clog2(COLD_LIMIT_SEC) : 1;
  typedef enum logic [2:0] {IDLE, INCUBATE, COLD, HATCHED, DEAD} state_t;
  state_t state_q, state_d;
  logic [3:0] num_q, num_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [CW-1:0] cold_q, cold_d;
  logic running_q, running_d, hatched_q, hatched_d, dead_q, dead_d;
  logic sec_tick;
  assign sec_tick = tick_q == TW'(TICKS_PER_SEC - 1);
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    tick_d  = tick_q;
    stage_d = stage_q;
    cold_d  = cold_q;
    if (start) begin
      state_d = INCUBATE;
      num_d   = '0;
      tick_d  = '0;
      stage_d = '0;
      cold_d  = '0;
    end else begin
      case (state_q)
        IDLE: num_d = '0;
        INCUBATE:
          if (!temp) begin
            state_d = COLD;
            tick_d  = '0;
            cold_d  = '0;
          end else begin
            tick_d = sec_tick ? '0 : tick_q + 1'b1;
            if (sec_tick) begin
              if (stage_q == SW'(STAGE_SEC - 1)) begin
                stage_d = '0;
                num_d   = num_q + 4'd1;
                if (num_d == 4'(LAST_STAGE)) state_d = HATCHED;
              end else stage_d = stage_q + 1'b1;
            end
          end
        COLD:
          // rewarming discards the partial second but keeps stage progress
          if (temp) begin
            state_d = INCUBATE;
            tick_d  = '0;
          end else begin
            tick_d = sec_tick ? '0 : tick_q + 1'b1;
            if (sec_tick) begin
              if (cold_q == CW'(COLD_LIMIT_SEC - 1)) begin
                state_d = DEAD;
                num_d   = 4'd15;
              end else cold_d = cold_q + 1'b1;
            end
          end
        HATCHED: num_d = 4'(LAST_STAGE);
        DEAD:    num_d = 4'd15;
        default: state_d = IDLE;
      endcase
    end
    running_d = state_d == INCUBATE || state_d == COLD;
    hatched_d = state_d == HATCHED;
    dead_d    = state_d == DEAD;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      num_q     <= '0;
      tick_q    <= '0;
      stage_q   <= '0;
      cold_q    <= '0;
      running_q <= 1'b0;
      hatched_q <= 1'b0;
      dead_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      tick_q    <= tick_d;
      stage_q   <= stage_d;
      cold_q    <= cold_d;
      running_q <= running_d;
      hatched_q <= hatched_d;
      dead_q    <= dead_d;
    end
  end
  assign num     = num_q;
  assign running = running_q;
  assign hatched = hatched_q;
  assign dead    = dead_q;
endmodule

// File: tb/tb_hatch_ctrl.sv
// tb_hatch_ctrl: vector table plus hand-written scenarios, with expected outputs queued per driven cycle.
module tb_hatch_ctrl;
  logic clk, rst, start, temp;
  logic [3:0] num;
  logic running, hatched, dead;
  hatch_ctrl #(.TICKS_PER_SEC(4), .STAGE_SEC(2), .COLD_LIMIT_SEC(3), .LAST_STAGE(11)) dut (
    .clk(clk), .rst(rst), .start(start), .temp(temp),
    .num(num), .running(running), .hatched(hatched), .dead(dead)
  );
  typedef struct {logic s; logic t; logic [3:0] n; logic r; logic h; logic d;} vec_t;
  typedef struct {logic [3:0] n; logic r; logic h; logic d;} exp_t;
  vec_t vt[19];
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic s, t, input logic [3:0] n, input logic r, h, d);
    vec_t v;
    v.s = s; v.t = t; v.n = n; v.r = r; v.h = h; v.d = d;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [3:0] n, input logic r, h, d);
    n_chk++;
    if ({num, running, hatched, dead} !== {n, r, h, d}) begin
      n_fail++;
      $display("FAIL %s @%0t: got num=%0d run=%b hat=%b dead=%b, want num=%0d run=%b hat=%b dead=%b",
               nm, $time, num, running, hatched, dead, n, r, h, d);
    end
  endtask
  task automatic step(input string nm, input logic s, t, input logic [3:0] n, input logic r, h, d);
    exp_t e;
    start = s;
    temp = t;
    e.n = n; e.r = r; e.h = h; e.d = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    e = sb.pop_front();
    chk(nm, e.n, e.r, e.h, e.d);
  endtask
  task automatic warm(input string nm);
    step(nm, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 138; c++)
      step(nm, 1'b0, 1'b1, c >= 88 ? 4'd11 : 4'(c / 8), c < 88, c >= 88, 1'b0);
  endtask
  initial begin
    clk = 0; rst = 1; start = 0; temp = 0;
    vt[0] = mk(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    vt[1] = mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    vt[2] = mk(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    vt[3] = mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 4; i <= 14; i++) vt[i] = mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    vt[15] = mk(1'b0, 1'b0, 4'd15, 1'b0, 1'b0, 1'b1);
    vt[16] = mk(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    vt[17] = mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    vt[18] = mk(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    #2 chk("reset_init", 4'd0, 1'b0, 1'b0, 1'b0);
    #10 rst = 0;
    @(posedge clk);
    #1;
    step("idle_ignores_temp", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) step($sformatf("table[%0d]", i), vt[i].s, vt[i].t, vt[i].n, vt[i].r, vt[i].h, vt[i].d);
    step("pre_async", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 10; c++) step("pre_async", 1'b0, 1'b1, 4'(c / 8), 1'b1, 1'b0, 1'b0);
    #2 rst = 1;
    #1 chk("async_reset", 4'd0, 1'b0, 1'b0, 1'b0);
    #2 rst = 0;
    warm("warm");
    step("cold_pause", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 16; c++)
      step("cold_pause", 1'b0, (c >= 6 && c < 10) ? 1'b0 : 1'b1, c >= 14 ? 4'd1 : 4'd0, 1'b1, 1'b0, 1'b0);
    step("death", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 53; c++)
      step("death", 1'b0, 1'b0, c >= 13 ? 4'd15 : 4'd0, c < 13, 1'b0, c >= 13);
    step("restart_mid", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 38; c++)
      step("restart_mid", c == 30, 1'b1, c < 30 ? 4'(c / 8) : 4'((c - 30) / 8), 1'b1, 1'b0, 1'b0);
    step("cold_rst", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 10; c++) step("cold_rst", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    #2 rst = 1;
    #1 chk("cold_rst_reset", 4'd0, 1'b0, 1'b0, 1'b0);
    #2 rst = 0;
    warm("warm_after_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
